// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter merging N_REQ AXI read-address channels onto one master
// port, with a global cap on outstanding bursts and ID-based R-channel routing.
module axi_rd_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int ADDR_W    = 48,
  parameter int DATA_W    = 256,
  parameter int MAX_OUTST = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ*ADDR_W-1:0] s_araddr,
  input  logic [N_REQ*8-1:0]      s_arlen,
  input  logic [N_REQ-1:0]        s_arvalid,
  output logic [N_REQ-1:0]        s_arready,
  output logic [DATA_W-1:0]       s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic [N_REQ-1:0]        s_rvalid,
  input  logic [N_REQ-1:0]        s_rready,
  output logic [ID_W-1:0]         m_axi_arid,
  output logic [ADDR_W-1:0]       m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_W-1:0]         m_axi_rid,
  input  logic [DATA_W-1:0]       m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  typedef enum logic {ARB, ISSUE} state_t;

  state_t           state, state_nx;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  idx;
  logic             found;
  logic [CNT_W-1:0] outst_cnt, cnt_nx;
  logic             s_hs;
  logic             r_done;

  // First requesting port at or after rr_ptr; the index wraps naturally in ID_W bits.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = rr_ptr + ID_W'(k);
      if (!found && s_arvalid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign s_hs = rstn && (state == ARB) && (outst_cnt < MAX_CNT) && found;

  always_comb begin
    s_arready = '0;
    if (s_hs) s_arready[winner] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ARB:     if (s_hs) state_nx = ISSUE;
      ISSUE:   if (m_axi_arready) state_nx = ARB;
      default: state_nx = ARB;
    endcase
  end

  // A completing rlast with nothing outstanding is ignored so the count cannot wrap.
  assign r_done = m_axi_rvalid && m_axi_rready && m_axi_rlast && (outst_cnt != '0);

  always_comb begin
    cnt_nx = outst_cnt;
    case ({s_hs, r_done})
      2'b10:   cnt_nx = outst_cnt + 1'b1;
      2'b01:   cnt_nx = outst_cnt - 1'b1;
      default: cnt_nx = outst_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= ARB;
      rr_ptr       <= '0;
      outst_cnt    <= '0;
      m_axi_araddr <= '0;
      m_axi_arlen  <= '0;
      m_axi_arid   <= '0;
    end else begin
      state     <= state_nx;
      outst_cnt <= cnt_nx;
      if (s_hs) begin
        m_axi_araddr <= s_araddr[ADDR_W*winner +: ADDR_W];
        m_axi_arlen  <= s_arlen[8*winner +: 8];
        m_axi_arid   <= winner;
        rr_ptr       <= winner + 1'b1;
      end
    end
  end

  assign m_axi_arvalid = (state == ISSUE);
  assign m_axi_arsize  = 3'($clog2(DATA_W / 8));
  assign m_axi_arburst = 2'b01;

  always_comb begin
    s_rvalid            = '0;
    s_rvalid[m_axi_rid] = m_axi_rvalid;
  end

  assign m_axi_rready = s_rready[m_axi_rid];
  assign s_rdata      = m_axi_rdata;
  assign s_rresp      = m_axi_rresp;
  assign s_rlast      = m_axi_rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_axi_rd_arbiter;
  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int AW   = 48;
  localparam int DW   = 256;
  localparam int MAXO = 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N*AW-1:0] s_araddr;
  logic [N*8-1:0]  s_arlen;
  logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rlast;
  logic [IDW-1:0]  m_axi_arid;
  logic [AW-1:0]   m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic [2:0]      m_axi_arsize;
  logic [1:0]      m_axi_arburst;
  logic            m_axi_arvalid, m_axi_arready;
  logic [IDW-1:0]  m_axi_rid;
  logic [DW-1:0]   m_axi_rdata;
  logic [1:0]      m_axi_rresp;
  logic            m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi_rd_arbiter dut (
    .clk(clk), .rstn(rstn),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one pending master request, a burst count and a pointer.
  bit            mv = 1'b0;
  bit            m_issue;
  int            m_id, m_ptr, m_outst;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_len;

  initial begin
    forever begin
      int w;
      logic [N-1:0] e;
      bit dec;
      @(negedge clk);
      w = -1;
      if (mv && rstn && !m_issue && m_outst < MAXO)
        for (int k = 0; k < N; k++)
          if (w < 0 && s_arvalid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (mv) begin
        e = '0;
        if (w >= 0) e[w] = 1'b1;
        chk("s_arready", s_arready, e);
        chk("m_arvalid", m_axi_arvalid, m_issue);
        chk("m_arid", m_axi_arid, m_id);
        chk("m_araddr", m_axi_araddr, m_addr);
        chk("m_arlen", m_axi_arlen, m_len);
        e = '0;
        if (m_axi_rvalid) e[m_axi_rid] = 1'b1;
        chk("s_rvalid", s_rvalid, e);
        chk("m_rready", m_axi_rready, s_rready[m_axi_rid]);
        chk("s_rdata", s_rdata, m_axi_rdata);
        chk("s_rresp", s_rresp, m_axi_rresp);
        chk("s_rlast", s_rlast, m_axi_rlast);
      end
      @(posedge clk);
      if (!rstn) begin
        mv = 1'b1; m_issue = 1'b0; m_id = 0; m_ptr = 0; m_outst = 0; m_addr = '0; m_len = '0;
      end else if (mv) begin
        dec = m_axi_rvalid && s_rready[m_axi_rid] && m_axi_rlast && (m_outst > 0);
        if (w >= 0) begin
          m_issue = 1'b1;
          m_id    = w;
          m_addr  = s_araddr[w*AW +: AW];
          m_len   = s_arlen[w*8 +: 8];
          m_ptr   = (w + 1) % N;
        end else if (m_issue && m_axi_arready) begin
          m_issue = 1'b0;
        end
        m_outst = m_outst + int'(w >= 0) - int'(dec);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic grant_one(input int idx);
    logic [N-1:0] e;
    e = '0;
    e[idx] = 1'b1;
    s_arvalid = e;
    m_axi_arready = 1'b1;
    settle();
    chk("grant_one", s_arready, e);
    tick();
    s_arvalid = '0;
    tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    int got[$];
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    int hi, beats;

    rstn = 1'b0; s_araddr = '0; s_arlen = '0; s_arvalid = '0; s_rready = '0;
    m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    repeat (3) tick();
    settle();
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_arlen", m_axi_arlen, 0);
    chk("rst_arid", m_axi_arid, 0);
    chk("rst_arready", s_arready, 0);
    chk("arsize", m_axi_arsize, 5);
    chk("arburst", m_axi_arburst, 1);

    // All requesters held: grants rotate 0,1,2,3,0 with arvalid every other cycle.
    for (int i = 0; i < N; i++) begin
      s_araddr[i*AW +: AW] = AW'(32'h100 * (i + 1));
      s_arlen[i*8 +: 8]    = 8'(i + 1);
    end
    s_arvalid = 4'hF; m_axi_arready = 1'b1; rstn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (m_axi_arvalid) got.push_back(int'(m_axi_arid));
    end
    chk("rr_pulses", got.size(), 5);
    for (int i = 0; i < 5; i++) chk("rr_order", (i < got.size()) ? got[i] : -1, exp_rr[i]);
    s_arvalid = '0;

    // Grant and rlast in the same cycle at 5 outstanding: count stays 5.
    s_arvalid = 4'b0010; m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rid = 2'd0; s_rready = 4'hF;
    settle();
    chk("same_cycle_grant", s_arready, 4'b0010);
    tick();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s_arvalid = '0;
    tick();
    grant_one(3); grant_one(0); grant_one(1);

    // Eight outstanding: a ninth request waits for one rlast.
    s_arvalid = 4'b0100;
    settle();
    chk("full_block", s_arready, 0);
    tick();
    settle();
    chk("full_block2", s_arready, 0);
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rid = 2'd1; s_rready = 4'hF;
    settle();
    chk("full_block3", s_arready, 0);
    tick();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    settle();
    chk("ninth_grant", s_arready, 4'b0100);
    tick();
    chk("ninth_arvalid", m_axi_arvalid, 1);
    chk("ninth_arid", m_axi_arid, 2);
    s_arvalid = '0;
    tick();

    // Stalled master: payload held stable for six cycles.
    do_reset();
    s_araddr[2*AW +: AW] = 48'h1000; s_arlen[2*8 +: 8] = 8'd15;
    s_arvalid = 4'b0100; m_axi_arready = 1'b0;
    tick();
    hi = 0;
    for (int c = 0; c < 6; c++) begin
      if (m_axi_arvalid) hi++;
      chk("stall_addr", m_axi_araddr, 48'h1000);
      chk("stall_len", m_axi_arlen, 15);
      chk("stall_id", m_axi_arid, 2);
      settle();
      chk("stall_arready", s_arready, 0);
      if (c == 5) begin
        m_axi_arready = 1'b1;
        s_arvalid = '0;
      end
      tick();
    end
    chk("stall_cycles", hi, 6);
    chk("stall_release", m_axi_arvalid, 0);

    // 16-beat burst to requester 3 with toggling ready; count drops by one only.
    grant_one(0); grant_one(1);
    m_axi_rid = 2'd3; beats = 0;
    for (int c = 0; c < 200 && beats < 16; c++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rlast  = (beats == 15);
      for (int j = 0; j < DW / 32; j++) m_axi_rdata[j*32 +: 32] = $urandom;
      s_rready = 4'($urandom);
      s_rready[3] = (c % 2 == 0);
      settle();
      chk("burst_rvalid", s_rvalid, 4'b1000);
      chk("burst_rready", m_axi_rready, (c % 2 == 0));
      if (s_rready[3]) beats++;
      tick();
    end
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    chk("burst_beats", beats, 16);
    for (int g = 0; g < 6; g++) grant_one(g % N);
    s_arvalid = 4'hF;
    settle();
    chk("after_burst_full", s_arready, 0);
    s_arvalid = '0;

    // Reset during ISSUE with three outstanding; search restarts from requester 0.
    do_reset();
    grant_one(3); grant_one(0);
    s_arvalid = 4'b0100; m_axi_arready = 1'b0;
    tick();
    s_arvalid = '0;
    tick();
    chk("pre_rst_arvalid", m_axi_arvalid, 1);
    rstn = 1'b0;
    tick();
    settle();
    chk("mid_rst_arvalid", m_axi_arvalid, 0);
    chk("mid_rst_araddr", m_axi_araddr, 0);
    chk("mid_rst_arlen", m_axi_arlen, 0);
    chk("mid_rst_arid", m_axi_arid, 0);
    chk("mid_rst_arready", s_arready, 0);
    rstn = 1'b1; s_arvalid = 4'b1010; m_axi_arready = 1'b1;
    settle();
    chk("post_rst_grant", s_arready, 4'b0010);
    tick();
    chk("post_rst_arid", m_axi_arid, 1);
    chk("post_rst_arvalid", m_axi_arvalid, 1);
    s_arvalid = '0;
    tick();

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      rstn = ($urandom_range(0, 199) != 0);
      s_arvalid = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        s_araddr[i*AW +: AW] = {16'($urandom), 32'($urandom)};
        s_arlen[i*8 +: 8]    = 8'($urandom);
      end
      m_axi_arready = ($urandom_range(0, 2) != 0);
      m_axi_rid     = 2'($urandom);
      m_axi_rvalid  = 1'($urandom);
      m_axi_rlast   = ($urandom_range(0, 3) == 0);
      m_axi_rresp   = 2'($urandom);
      for (int j = 0; j < DW / 32; j++) m_axi_rdata[j*32 +: 32] = $urandom;
      s_rready = 4'($urandom);
      tick();
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
